// File: rtl/spi_master_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_param                                             |
// | Description : Parametrised full-duplex SPI master. One transfer per start  |
// |               to one of NUM_SLAVES chip selects, per-transfer CPOL/CPHA    |
// |               and bit order, serial clock divided down from SCLK.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2,
  parameter int SEL_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  slave_select,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_err,
  output logic                  sck,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic                  mosi
);

  // Counter widths: divider counts 0..CLK_DIV-1, half-period counter 0..2*DATA_WIDTH-1.
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0]      DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0]     HALF_LAST   = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [SEL_WIDTH:0]    SLAVE_LIMIT = (SEL_WIDTH + 1)'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] CS_IDLE     = {NUM_SLAVES{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_TRANSFER = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // Current-state registers
  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [HALF_W-1:0]       half_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic                    mode_cpol;
  logic                    mode_cpha;
  logic                    mode_lsb;
  logic                    sck_q;
  logic                    mosi_q;
  logic [NUM_SLAVES-1:0]   cs_n_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    sel_err_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;

  // Next-state values
  state_t                  state_nx;
  logic [DIV_W-1:0]        div_nx;
  logic [HALF_W-1:0]       half_nx;
  logic [DATA_WIDTH-1:0]   tx_nx;
  logic [DATA_WIDTH-1:0]   rx_nx;
  logic                    mode_cpol_nx;
  logic                    mode_cpha_nx;
  logic                    mode_lsb_nx;
  logic                    sck_nx;
  logic                    mosi_nx;
  logic [NUM_SLAVES-1:0]   cs_n_nx;
  logic                    busy_nx;
  logic                    done_nx;
  logic                    sel_err_nx;
  logic [DATA_WIDTH-1:0]   rx_data_nx;

  // Helper terms
  logic                    div_tick;
  logic                    leading_half;
  logic                    last_half;
  logic                    sel_valid;
  logic                    first_bit;
  logic                    tx_head;
  logic                    tx_next_head;
  logic [DATA_WIDTH-1:0]   tx_shifted;
  logic [DATA_WIDTH-1:0]   rx_sampled;
  logic [NUM_SLAVES-1:0]   cs_decode;

  assign div_tick     = (div_cnt == DIV_LAST);
  // Half-periods alternate leading/trailing starting with a leading one.
  assign leading_half = ~half_cnt[0];
  assign last_half    = (half_cnt == HALF_LAST);
  assign sel_valid    = ({1'b0, slave_select} < SLAVE_LIMIT);
  assign first_bit    = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];

  // Shift directions follow the bit order captured at start acceptance.
  assign tx_head      = mode_lsb ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
  assign tx_next_head = mode_lsb ? tx_shift[1] : tx_shift[DATA_WIDTH-2];
  assign tx_shifted   = mode_lsb ? {1'b0, tx_shift[DATA_WIDTH-1:1]}
                                 : {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign rx_sampled   = mode_lsb ? {miso, rx_shift[DATA_WIDTH-1:1]}
                                 : {rx_shift[DATA_WIDTH-2:0], miso};

  // One-hot-low decode of the requested chip select.
  always_comb begin
    cs_decode = CS_IDLE;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      cs_decode[i] = (slave_select != SEL_WIDTH'(i));
    end
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_nx     = state;
    div_nx       = div_cnt;
    half_nx      = half_cnt;
    tx_nx        = tx_shift;
    rx_nx        = rx_shift;
    mode_cpol_nx = mode_cpol;
    mode_cpha_nx = mode_cpha;
    mode_lsb_nx  = mode_lsb;
    sck_nx       = sck_q;
    mosi_nx      = mosi_q;
    cs_n_nx      = cs_n_q;
    busy_nx      = busy_q;
    done_nx      = 1'b0;
    sel_err_nx   = 1'b0;
    rx_data_nx   = rx_data_q;

    case (state)
      ST_IDLE: begin
        // Mode tracks the inputs every idle cycle so sck already sits at the
        // requested idle level before a transfer begins.
        mode_cpol_nx = cpol;
        mode_cpha_nx = cpha;
        mode_lsb_nx  = lsb_first;
        sck_nx       = cpol;
        mosi_nx      = 1'b0;
        cs_n_nx      = CS_IDLE;
        busy_nx      = 1'b0;
        div_nx       = '0;
        half_nx      = '0;
        if (start) begin
          if (sel_valid) begin
            tx_nx    = tx_data;
            rx_nx    = '0;
            cs_n_nx  = cs_decode;
            busy_nx  = 1'b1;
            // CPHA=0 slaves sample on the first edge, so bit 0 must be out now.
            mosi_nx  = cpha ? 1'b0 : first_bit;
            state_nx = ST_SETUP;
          end else begin
            sel_err_nx = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (div_tick) begin
          div_nx   = '0;
          half_nx  = '0;
          state_nx = ST_TRANSFER;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      ST_TRANSFER: begin
        if (div_tick) begin
          div_nx  = '0;
          sck_nx  = ~sck_q;
          half_nx = half_cnt + 1'b1;
          if (leading_half) begin
            if (!mode_cpha) begin
              rx_nx = rx_sampled;
            end else begin
              mosi_nx = tx_head;
              tx_nx   = tx_shifted;
            end
          end else begin
            if (mode_cpha) begin
              rx_nx = rx_sampled;
            end else if (!last_half) begin
              // The final trailing edge has no further bit to present.
              mosi_nx = tx_next_head;
              tx_nx   = tx_shifted;
            end
          end
          if (last_half) begin
            half_nx  = '0;
            state_nx = ST_HOLD;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        if (div_tick) begin
          div_nx     = '0;
          cs_n_nx    = CS_IDLE;
          mosi_nx    = 1'b0;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          rx_data_nx = rx_shift;
          state_nx   = ST_IDLE;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered outputs; every output is a flop so sck and cs_n
  // cannot glitch.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      half_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      mode_cpol <= 1'b0;
      mode_cpha <= 1'b0;
      mode_lsb  <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= CS_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      div_cnt   <= div_nx;
      half_cnt  <= half_nx;
      tx_shift  <= tx_nx;
      rx_shift  <= rx_nx;
      mode_cpol <= mode_cpol_nx;
      mode_cpha <= mode_cpha_nx;
      mode_lsb  <= mode_lsb_nx;
      sck_q     <= sck_nx;
      mosi_q    <= mosi_nx;
      cs_n_q    <= cs_n_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      sel_err_q <= sel_err_nx;
      rx_data_q <= rx_data_nx;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_err = sel_err_q;
  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_param                                          |
// | Description : Self-checking bench for spi_master_param: vector table,      |
// |               random transfers against a slave model, reset and            |
// |               back-to-back sequences.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master_param;

  logic SCLK;
  logic reset;

  // DUT A: defaults (8 bits, 3 slaves, divide by 2)
  logic       start_a, cpol_a, cpha_a, lsb_a, miso_a, miso_s, loop_a;
  logic [1:0] sel_a;
  logic [7:0] tx_a, rx_a;
  logic       busy_a, done_a, sel_err_a, sck_a, mosi_a;
  logic [2:0] cs_n_a;

  // DUT B: 16 bits, divide by 1, miso looped back
  logic        start_b, cpol_b, cpha_b, lsb_b;
  logic [1:0]  sel_b;
  logic [15:0] tx_b, rx_b;
  logic        busy_b, done_b, sel_err_b, sck_b, mosi_b;
  logic [2:0]  cs_n_b;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_param dut_a (
    .SCLK(SCLK), .reset(reset), .start(start_a), .slave_select(sel_a),
    .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .tx_data(tx_a),
    .miso(miso_a), .rx_data(rx_a), .busy(busy_a), .done(done_a),
    .sel_err(sel_err_a), .sck(sck_a), .cs_n(cs_n_a), .mosi(mosi_a)
  );

  spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(3), .CLK_DIV(1)) dut_b (
    .SCLK(SCLK), .reset(reset), .start(start_b), .slave_select(sel_b),
    .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .tx_data(tx_b),
    .miso(mosi_b), .rx_data(rx_b), .busy(busy_b), .done(done_b),
    .sel_err(sel_err_b), .sck(sck_b), .cs_n(cs_n_b), .mosi(mosi_b)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  assign miso_a = loop_a ? mosi_a : miso_s;

  // ---------------- behavioural slave for DUT A ----------------
  logic       s_cpol, s_cpha, s_lsb, mon_en;
  logic [7:0] s_word, s_mosi;
  int         s_drv, s_smp, s_edges, cs_viol;
  logic       prev_sck;
  logic [2:0] prev_cs;
  logic       s_act, s_prev_act, s_lead;

  assign s_act      = (cs_n_a != 3'b111);
  assign s_prev_act = (prev_cs != 3'b111);
  assign s_lead     = (sck_a != s_cpol);

  function automatic logic wbit(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i[2:0]] : w[3'(7 - i)];
  endfunction

  // Slave reacts to sck/cs_n as seen between clock edges.
  always @(negedge SCLK) begin
    if (mon_en && (cs_n_a != prev_cs) && ((sck_a != prev_sck) || (sck_a != s_cpol)))
      cs_viol <= cs_viol + 1;
    if (s_act && !s_prev_act) begin
      s_drv   <= 0;
      s_smp   <= 0;
      s_edges <= 0;
      s_mosi  <= 8'h00;
      if (!s_cpha) miso_s <= wbit(s_word, 0, s_lsb);
    end else if (s_act && (sck_a != prev_sck)) begin
      s_edges <= s_edges + 1;
      if (s_lead ^ s_cpha) begin
        if (s_smp < 8) s_mosi[s_lsb ? 3'(s_smp) : 3'(7 - s_smp)] <= mosi_a;
        s_smp <= s_smp + 1;
      end else if (s_cpha) begin
        if (s_drv < 8) miso_s <= wbit(s_word, s_drv, s_lsb);
        s_drv <= s_drv + 1;
      end else begin
        if (s_drv + 1 < 8) miso_s <= wbit(s_word, s_drv + 1, s_lsb);
        s_drv <= s_drv + 1;
      end
    end
    prev_sck <= sck_a;
    prev_cs  <= cs_n_a;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cpol, cpha, lsb;
    logic [1:0] sel;
    logic [7:0] tx, sword;
    logic       loop;
    logic [7:0] exp_rx;
    logic [2:0] exp_cs;
    logic       exp_err;
  } vec_t;

  logic [7:0] last_rx;

  // Reference: rx equals the slave's word (or tx when looped back), only
  // selects below 3 are valid, latency is CLK_DIV*(2*DATA_WIDTH+2) = 36.
  function automatic vec_t model(input vec_t v, input logic [7:0] prev_rx);
    vec_t r = v;
    r.exp_err = (v.sel >= 2'd3);
    r.exp_rx  = r.exp_err ? prev_rx : (v.loop ? v.tx : v.sword);
    r.exp_cs  = r.exp_err ? 3'b111 : (3'b111 ^ (3'b001 << v.sel));
    return r;
  endfunction

  task automatic run_a(input vec_t v, input int restart_at);
    int m, bad;
    @(negedge SCLK);
    cpol_a = v.cpol; cpha_a = v.cpha; lsb_a = v.lsb; start_a = 1'b0;
    s_cpol = v.cpol; s_cpha = v.cpha; s_lsb = v.lsb; s_word = v.sword; loop_a = v.loop;
    repeat (2) @(negedge SCLK);
    chk("idle_sck", 32'(sck_a), 32'(v.cpol));
    tx_a = v.tx; sel_a = v.sel; start_a = 1'b1;
    @(negedge SCLK);
    start_a = 1'b0;
    if (v.exp_err) begin
      chk("sel_err_pulse", 32'(sel_err_a), 32'd1);
      chk("sel_err_cs", 32'(cs_n_a), 32'b111);
      chk("sel_err_busy", 32'(busy_a), 32'd0);
      @(negedge SCLK);
      chk("sel_err_width", 32'(sel_err_a), 32'd0);
      repeat (4) @(negedge SCLK);
      chk("sel_err_sck", 32'(sck_a), 32'(v.cpol));
      chk("sel_err_rx", 32'(rx_a), 32'(v.exp_rx));
      return;
    end
    // Inputs other than start are scrambled to prove they are ignored.
    tx_a = 8'($urandom); sel_a = 2'($urandom); cpol_a = 1'($urandom);
    cpha_a = 1'($urandom); lsb_a = 1'($urandom);
    chk("accept_busy", 32'(busy_a), 32'd1);
    m = 0; bad = 0;
    while (done_a !== 1'b1 && m < 200) begin
      if (cs_n_a !== v.exp_cs || busy_a !== 1'b1) bad++;
      start_a = (m == restart_at);
      if (m == restart_at) tx_a = ~v.tx;
      @(negedge SCLK);
      m++;
    end
    start_a = 1'b0;
    chk("latency", 32'(m), 32'd36);
    chk("cs_busy_during", 32'(bad), 32'd0);
    chk("done_busy", 32'(busy_a), 32'd0);
    chk("done_cs", 32'(cs_n_a), 32'b111);
    chk("rx_data", 32'(rx_a), 32'(v.exp_rx));
    chk("sck_edges", 32'(s_edges), 32'd16);
    chk("mosi_word", 32'(s_mosi), 32'(v.tx));
    @(negedge SCLK);
    chk("done_width", 32'(done_a), 32'd0);
    last_rx = v.exp_rx;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int m, dcnt;

    reset = 1'b1; mon_en = 1'b0; cs_viol = 0;
    start_a = 0; cpol_a = 0; cpha_a = 0; lsb_a = 0; sel_a = 0; tx_a = 0; loop_a = 0;
    s_cpol = 0; s_cpha = 0; s_lsb = 0; s_word = 0; miso_s = 0;
    start_b = 0; cpol_b = 0; cpha_b = 0; lsb_b = 0; sel_b = 0; tx_b = 0;
    last_rx = 8'h00;

    //         cpol  cpha  lsb   sel    tx     sword  loop  exp_rx cs      err
    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 3'b110, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'h3C, 8'hC3, 1'b0, 8'hC3, 3'b011, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'h55, 8'hAA, 1'b0, 8'hC3, 3'b111, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h96, 8'h5A, 1'b0, 8'h5A, 3'b101, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'hF0, 8'h0E, 1'b0, 8'h0E, 3'b110, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h81, 8'h00, 1'b1, 8'h81, 3'b101, 1'b0};

    repeat (3) @(negedge SCLK);
    chk("rst_rx", 32'(rx_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_sel_err", 32'(sel_err_a), 32'd0);
    chk("rst_sck", 32'(sck_a), 32'd0);
    chk("rst_cs", 32'(cs_n_a), 32'b111);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    reset = 1'b0;
    @(negedge SCLK);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_a(tbl[i], -1);

    // Second start with different data mid-transfer must be ignored.
    v = '{1'b0, 1'b0, 1'b0, 2'd1, 8'h69, 8'h3E, 1'b0, 8'h3E, 3'b101, 1'b0};
    run_a(v, 5);

    for (int i = 0; i < 16; i++) begin
      v.cpol = 1'($urandom); v.cpha = 1'($urandom); v.lsb = 1'($urandom);
      v.sel = 2'($urandom_range(0, 3)); v.tx = 8'($urandom); v.sword = 8'($urandom);
      v.loop = 1'b0;
      v = model(v, last_rx);
      run_a(v, -1);
    end

    // Reset in the middle of a mode-3 transfer.
    @(negedge SCLK);
    cpol_a = 1; cpha_a = 1; lsb_a = 0; s_cpol = 1; s_cpha = 1; s_lsb = 0;
    s_word = 8'h77; loop_a = 0;
    repeat (2) @(negedge SCLK);
    tx_a = 8'h5A; sel_a = 2'd0; start_a = 1'b1;
    @(negedge SCLK);
    start_a = 1'b0;
    repeat (10) @(negedge SCLK);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_cs", 32'(cs_n_a), 32'b111);
    chk("midrst_sck", 32'(sck_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_rx", 32'(rx_a), 32'd0);
    chk("midrst_mosi", 32'(mosi_a), 32'd0);
    @(negedge SCLK);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge SCLK);
      if (done_a === 1'b1) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    chk("midrst_idle_busy", 32'(busy_a), 32'd0);
    mon_en = 1'b1;
    chk("cs_vs_sck", 32'(cs_viol), 32'd0);

    // DUT B: start held high, two back-to-back 16-bit transfers.
    @(negedge SCLK);
    sel_b = 2'd1; tx_b = 16'h1234; start_b = 1'b1;
    @(negedge SCLK);
    tx_b = 16'hBEEF;
    chk("b_accept_busy", 32'(busy_b), 32'd1);
    m = 0;
    while (done_b !== 1'b1 && m < 200) begin @(negedge SCLK); m++; end
    chk("b_latency1", 32'(m), 32'd34);
    chk("b_gap_cs", 32'(cs_n_b), 32'b111);
    chk("b_gap_busy", 32'(busy_b), 32'd0);
    chk("b_rx1", 32'(rx_b), 32'h1234);
    @(negedge SCLK);
    start_b = 1'b0;
    chk("b_second_busy", 32'(busy_b), 32'd1);
    chk("b_second_cs", 32'(cs_n_b), 32'b101);
    m = 0;
    while (done_b !== 1'b1 && m < 200) begin @(negedge SCLK); m++; end
    chk("b_latency2", 32'(m), 32'd34);
    chk("b_rx2", 32'(rx_b), 32'hBEEF);
    @(negedge SCLK);
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the serial-peripheral-interface workspace. It performs one full-duplex transfer per `start` to one of `NUM_SLAVES` chip selects. Word width, slave count and serial-clock divider are configurable; SPI mode (CPOL/CPHA) and bit order are selectable per transfer. It generates its own divided serial clock from `SCLK`, gives `busy`/`done` handshakes, and rejects out-of-range slave indices.

## Interface
- `DATA_WIDTH`, 8: bits per transfer, ≥2.
- `NUM_SLAVES`, 3: number of chip-select lines, ≥1.
- `CLK_DIV`, 2: `SCLK` cycles per half `sck` period, ≥1.
- `SEL_WIDTH`, `$clog2(NUM_SLAVES)` (min 1): width of `slave_select`.
- `SCLK`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `slave_select`  in  SEL_WIDTH  target slave index.
- `cpol`  in  1  idle level of `sck`.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- `lsb_first`  in  1  1 = LSB shifted first.
- `tx_data`  in  DATA_WIDTH  word to send.
- `miso`  in  1  serial data from slave.
- `rx_data`  out  DATA_WIDTH  last received word; held until the next `done`.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse at end of transfer.
- `sel_err`  out  1  one-cycle pulse when `slave_select` ≥ NUM_SLAVES.
- `sck`  out  1  serial clock.
- `cs_n`  out  NUM_SLAVES  active-low chip selects; at most one low.
- `mosi`  out  1  serial data to slave.

## Operation
- Reset values: `rx_data`=0, `busy`=0, `done`=0, `sel_err`=0, `sck`=0, `cs_n`=all 1, `mosi`=0, state IDLE, mode registers 0.
- IDLE: mode registers load `cpol`/`cpha`/`lsb_first` every cycle. `sck` = registered cpol. `mosi`=0.
- On `start`=1 in IDLE with a valid select:
  - Capture `tx_data`, `slave_select` and mode into the shift register and config.
  - Drive `cs_n[slave_select]`=0 and `busy`=1.
  - Go to SETUP.
- On `start`=1 in IDLE with an invalid select: pulse `sel_err` for one cycle; stay in IDLE; no `cs_n` or `sck` activity.
- SETUP (CLK_DIV cycles): CPHA=0 puts the first bit on `mosi` at entry. CPHA=1 leaves `mosi` at 0.
- TRANSFER: 2·DATA_WIDTH half-periods of CLK_DIV cycles each. `sck` toggles at the end of every half-period.
  - CPHA=0: leading edge samples `miso`; trailing edge shifts out the next bit. No shift after the last sample.
  - CPHA=1: leading edge drives the next bit; trailing edge samples `miso`.
  - Bit order follows captured `lsb_first`, for both tx and rx.
- HOLD (CLK_DIV cycles): `sck` at idle level, `cs_n` still asserted.
- End of HOLD:
  - Release `cs_n`, load `rx_data` from the shift register, pulse `done`.
  - Drop `busy` in the same cycle and return to IDLE.
- Input changes during a transfer are ignored, including `start`, data, select and mode.
- Reset mid-transfer: all outputs return to reset values immediately. No `done`. `rx_data` is cleared.

## Timing
- `start` sampled at edge k. SETUP begins with outputs valid after edge k.
- `done` high for exactly one cycle, after edge k + CLK_DIV·(2·DATA_WIDTH+2). `busy` is low from that same edge.
- Defaults (CLK_DIV=2, DATA_WIDTH=8): 36 cycles from start acceptance to `done`. Exactly 16 `sck` edges.
- `start` held high: a new transfer is accepted on the first IDLE cycle after `done`. Back-to-back gap is 1 cycle with `cs_n` high.
- `sck` never glitches. `cs_n` changes only while `sck` is at idle level.

## Test plan
- Mode 0, MSB first, defaults, `tx_data`=0xA5, `miso` looped to `mosi`:
  - `rx_data`=0xA5.
  - `cs_n`=3'b110 for 36 cycles.
  - 8 rising then falling `sck` pairs.
  - `done` at cycle 36.
- Mode 3, `lsb_first`=1, slave 2, `tx_data`=0x3C, slave model returns 0xC3 LSB-first:
  - `mosi` bit sequence is 0,0,1,1,1,1,0,0.
  - `rx_data`=0xC3.
  - `sck` idles high.
  - `cs_n`=3'b011.
- `slave_select`=3 with NUM_SLAVES=3: `sel_err` is a one-cycle pulse; `cs_n` stays 3'b111; `busy`=0; no `sck` edge.
- Reset asserted at cycle 10 of a transfer: `cs_n`=all 1, `sck`=0, `busy`=0, `rx_data`=0 at once. No `done` follows.
- `start` pulsed again at cycle 5 of a transfer with different `tx_data`: ignored; first transfer completes unchanged.
- `start` held high, DATA_WIDTH=16, CLK_DIV=1: two back-to-back transfers. Each takes 34 cycles, with a 1-cycle `cs_n`-high gap between them.
